// File: rtl/arp_reply_ctrl.sv
// arp_reply_ctrl: filters decoded ARP requests addressed to LOCAL_IP, queues reply jobs
// {sha,spa}, and arbitrates the single MAC TX path between ARP replies and the IP
// transmitter, with a forced inter-frame gap and a stuck-transmitter timeout.
module arp_reply_ctrl #(
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80164,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned IFG_CYCLES = 24,
    parameter int unsigned TX_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_arp_done,
    input  logic        i_arp_err,
    input  logic [47:0] i_arp_sha,
    input  logic [31:0] i_arp_spa,
    input  logic [31:0] i_arp_tpa,
    input  logic        i_ip_req,
    input  logic        i_ip_done,
    output logic        o_ip_grant,
    output logic        o_arp_tx_start,
    output logic [47:0] o_arp_tx_tha,
    output logic [31:0] o_arp_tx_tpa,
    input  logic        i_arp_tx_done,
    output logic        o_tx_timeout,
    output logic [7:0]  o_drop_cnt,
    output logic        o_busy
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(TX_TIMEOUT + 1);
    localparam int unsigned GAP_W  = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StArpStart, StArpWait, StIpWait, StGap} state_e;

    // Reply-job queue
    logic [79:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_arp_done_q;
    logic [7:0]        r_drop_cnt;

    // Arbiter / FSM state
    state_e            r_state;
    logic              r_last_arp;   // 1: ARP was served last, 0: IP was served last
    logic              r_start;
    logic              r_grant;
    logic              r_timeout;
    logic [47:0]       r_tha;
    logic [31:0]       r_tpa;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;

    logic              w_capture;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_arp_pend;
    logic [79:0]       w_head;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_wait_hit;

    // A request counts only on the rising edge of the decoder's done level.
    assign w_capture  = i_arp_done & ~r_arp_done_q & ~i_arp_err & (i_arp_tpa == LOCAL_IP);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop      = (r_state == StArpStart) && (r_count != '0);
    // A pop in the same cycle frees the slot, so a push against a full queue still lands.
    assign w_push     = w_capture & (~w_full | w_pop);
    assign w_drop     = w_capture & w_full & ~w_pop;
    assign w_arp_pend = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_wait_nxt = r_wait_cnt + 1'b1;
    assign w_wait_hit = (w_wait_nxt == WAIT_W'(TX_TIMEOUT));

    assign o_ip_grant     = r_grant;
    assign o_arp_tx_start = r_start;
    assign o_arp_tx_tha   = r_tha;
    assign o_arp_tx_tpa   = r_tpa;
    assign o_tx_timeout   = r_timeout;
    assign o_drop_cnt     = r_drop_cnt;
    assign o_busy         = (r_state != StIdle) || w_arp_pend;

    // Queue payload storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_arp_sha, i_arp_spa};
        end
    end

    // Queue pointers, occupancy, done-edge history and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_arp_done_q <= 1'b0;
            r_drop_cnt   <= 8'd0;
        end else begin
            r_arp_done_q <= i_arp_done;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // TX-path arbiter FSM with registered start/grant/timeout/target outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_last_arp <= 1'b0;
            r_start    <= 1'b0;
            r_grant    <= 1'b0;
            r_timeout  <= 1'b0;
            r_tha      <= 48'd0;
            r_tpa      <= 32'd0;
            r_wait_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // On a tie, the side not served last wins.
                    if (w_arp_pend && (!i_ip_req || !r_last_arp)) begin
                        r_state <= StArpStart;
                        r_start <= 1'b1;
                        r_tha   <= w_head[79:32];
                        r_tpa   <= w_head[31:0];
                    end else if (i_ip_req) begin
                        r_state    <= StIpWait;
                        r_grant    <= 1'b1;
                        r_last_arp <= 1'b0;
                        r_wait_cnt <= '0;
                    end
                end
                StArpStart: begin
                    r_state    <= StArpWait;
                    r_last_arp <= 1'b1;
                    r_wait_cnt <= '0;
                end
                StArpWait: begin
                    r_wait_cnt <= w_wait_nxt;
                    if (i_arp_tx_done) begin
                        r_state   <= StGap;
                        r_gap_cnt <= '0;
                    end else if (w_wait_hit) begin
                        // Job is abandoned, not retried.
                        r_timeout <= 1'b1;
                        r_state   <= StGap;
                        r_gap_cnt <= '0;
                    end
                end
                StIpWait: begin
                    r_wait_cnt <= w_wait_nxt;
                    if (i_ip_done) begin
                        r_grant   <= 1'b0;
                        r_state   <= StGap;
                        r_gap_cnt <= '0;
                    end else if (w_wait_hit) begin
                        r_grant   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= StGap;
                        r_gap_cnt <= '0;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
                        r_state <= StIdle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_reply_ctrl.sv
// tb_arp_reply_ctrl: directed, table-driven bench for arp_reply_ctrl plus hand-written
// sequences for queue overflow, arbitration order, timeout and mid-frame reset.
module tb_arp_reply_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_arp_done;
    logic        i_arp_err;
    logic [47:0] i_arp_sha;
    logic [31:0] i_arp_spa;
    logic [31:0] i_arp_tpa;
    logic        i_ip_req;
    logic        i_ip_done;
    logic        o_ip_grant;
    logic        o_arp_tx_start;
    logic [47:0] o_arp_tx_tha;
    logic [31:0] o_arp_tx_tpa;
    logic        i_arp_tx_done;
    logic        o_tx_timeout;
    logic [7:0]  o_drop_cnt;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int kind;
    int dt;
    int arp_idx;
    int starts_seen;
    int grants_seen;

    localparam logic [31:0] LIP = 32'hC0A80164;

    typedef struct {
        logic [31:0] tpa;
        logic        err;
        logic [47:0] sha;
        logic [31:0] spa;
        logic        exp_start;
    } vec_t;

    vec_t        vecs [6];
    int          exp_kind [5];
    logic [47:0] exp_sha [3];
    logic [31:0] exp_spa [3];

    arp_reply_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_arp_done     (i_arp_done),
        .i_arp_err      (i_arp_err),
        .i_arp_sha      (i_arp_sha),
        .i_arp_spa      (i_arp_spa),
        .i_arp_tpa      (i_arp_tpa),
        .i_ip_req       (i_ip_req),
        .i_ip_done      (i_ip_done),
        .o_ip_grant     (o_ip_grant),
        .o_arp_tx_start (o_arp_tx_start),
        .o_arp_tx_tha   (o_arp_tx_tha),
        .o_arp_tx_tpa   (o_arp_tx_tpa),
        .i_arp_tx_done  (i_arp_tx_done),
        .o_tx_timeout   (o_tx_timeout),
        .o_drop_cnt     (o_drop_cnt),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one decoder completion in the current cycle; returns one cycle later.
    task automatic arp_request(input logic [47:0] sha, input logic [31:0] spa,
                               input logic [31:0] tpa, input logic err);
        i_arp_sha  = sha;
        i_arp_spa  = spa;
        i_arp_tpa  = tpa;
        i_arp_err  = err;
        i_arp_done = 1'b1;
        tick();
        i_arp_done = 1'b0;
        i_arp_err  = 1'b0;
    endtask

    // Called in the start cycle S; pulses done at S+w, checks targets held, returns at S+w+1.
    task automatic finish_arp(input int w, input logic [47:0] sha, input logic [31:0] spa,
                              input string tag);
        repeat (w) tick();
        check({tag, " tha held at done"}, o_arp_tx_tha, sha);
        check({tag, " tpa held at done"}, o_arp_tx_tpa, spa);
        i_arp_tx_done = 1'b1;
        tick();
        i_arp_tx_done = 1'b0;
    endtask

    // kind: 1 = arp_tx_start, 2 = ip_grant, 0 = nothing within max cycles.
    task automatic wait_event(input int max, output int k, output int d);
        k = 0;
        d = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (o_arp_tx_start) begin
                k = 1;
                d = i;
                break;
            end
            if (o_ip_grant) begin
                k = 2;
                d = i;
                break;
            end
        end
    endtask

    initial begin
        vecs[0] = '{LIP,          1'b0, 48'h020000000001, 32'hC0A80102, 1'b1};
        vecs[1] = '{32'hC0A80165, 1'b0, 48'h020000000002, 32'hC0A80103, 1'b0};
        vecs[2] = '{LIP,          1'b1, 48'h020000000003, 32'hC0A80104, 1'b0};
        vecs[3] = '{LIP,          1'b0, 48'hAABBCCDDEEFF, 32'h0A000001, 1'b1};
        vecs[4] = '{32'h00000000, 1'b0, 48'h111111111111, 32'h22222222, 1'b0};
        vecs[5] = '{LIP,          1'b0, 48'hFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b1};

        rst           = 1'b1;
        i_arp_done    = 1'b0;
        i_arp_err     = 1'b0;
        i_arp_sha     = '0;
        i_arp_spa     = '0;
        i_arp_tpa     = '0;
        i_ip_req      = 1'b0;
        i_ip_done     = 1'b0;
        i_arp_tx_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        check("reset grant", o_ip_grant, 0);
        check("reset start", o_arp_tx_start, 0);
        check("reset tha", o_arp_tx_tha, 0);
        check("reset tpa", o_arp_tx_tpa, 0);
        check("reset timeout", o_tx_timeout, 0);
        check("reset drop", o_drop_cnt, 0);
        check("reset busy", o_busy, 0);

        // Filtering table: start at N+2 only for valid requests to LOCAL_IP.
        for (int v = 0; v < 6; v++) begin
            arp_request(vecs[v].sha, vecs[v].spa, vecs[v].tpa, vecs[v].err);
            check($sformatf("vec%0d start at N+1", v), o_arp_tx_start, 0);
            tick();
            check($sformatf("vec%0d start at N+2", v), o_arp_tx_start, vecs[v].exp_start);
            if (vecs[v].exp_start) begin
                check($sformatf("vec%0d tha", v), o_arp_tx_tha, vecs[v].sha);
                check($sformatf("vec%0d tpa", v), o_arp_tx_tpa, vecs[v].spa);
                finish_arp(10, vecs[v].sha, vecs[v].spa, $sformatf("vec%0d", v));
                repeat (23) tick();
                check($sformatf("vec%0d busy last gap cycle", v), o_busy, 1);
                tick();
                check($sformatf("vec%0d busy after gap", v), o_busy, 0);
            end else begin
                check($sformatf("vec%0d busy ignored", v), o_busy, 0);
            end
            check($sformatf("vec%0d drop", v), o_drop_cnt, 0);
        end

        // Three requests during a long IP grant: depth 2 keeps the first two, drops one.
        i_ip_req = 1'b1;
        check("ovf grant before decision", o_ip_grant, 0);
        tick();
        check("ovf grant rises", o_ip_grant, 1);
        tick();
        i_ip_req = 1'b0;
        arp_request(48'h0A0000000001, 32'hC0A8010A, LIP, 1'b0);
        tick();
        arp_request(48'h0B0000000002, 32'hC0A8010B, LIP, 1'b0);
        tick();
        arp_request(48'h0C0000000003, 32'hC0A8010C, LIP, 1'b0);
        check("ovf drop count", o_drop_cnt, 1);
        check("ovf busy", o_busy, 1);
        repeat (490) tick();
        check("ovf grant held without ip_req", o_ip_grant, 1);
        i_ip_done = 1'b1;
        check("ovf grant in done cycle", o_ip_grant, 1);
        tick();
        i_ip_done = 1'b0;
        check("ovf grant after done", o_ip_grant, 0);
        wait_event(40, kind, dt);
        check("ovf first kind", kind, 1);
        check("ovf first delay", dt, 25);
        check("ovf first tha", o_arp_tx_tha, 48'h0A0000000001);
        finish_arp(10, 48'h0A0000000001, 32'hC0A8010A, "ovf first");
        wait_event(40, kind, dt);
        check("ovf second kind", kind, 1);
        check("ovf second delay", dt, 25);
        check("ovf second tha", o_arp_tx_tha, 48'h0B0000000002);
        finish_arp(10, 48'h0B0000000002, 32'hC0A8010B, "ovf second");
        wait_event(60, kind, dt);
        check("ovf no third reply", kind, 0);
        check("ovf busy end", o_busy, 0);

        // Round-robin with ip_req held: prime an IP grant so IP is last served.
        exp_kind = '{1, 2, 1, 2, 1};
        exp_sha  = '{48'h0D0000000001, 48'h0D0000000002, 48'h0D0000000003};
        exp_spa  = '{32'h0A0A0A01, 32'h0A0A0A02, 32'h0A0A0A03};
        i_ip_req = 1'b1;
        tick();
        check("rr prime grant", o_ip_grant, 1);
        arp_request(exp_sha[0], exp_spa[0], LIP, 1'b0);
        tick();
        arp_request(exp_sha[1], exp_spa[1], LIP, 1'b0);
        repeat (4) tick();
        i_ip_done = 1'b1;
        tick();
        i_ip_done = 1'b0;
        arp_idx = 0;
        for (int e = 0; e < 5; e++) begin
            wait_event(40, kind, dt);
            check($sformatf("rr event%0d kind", e), kind, exp_kind[e]);
            check($sformatf("rr event%0d delay", e), dt, 25);
            if (kind == 1) begin
                check($sformatf("rr event%0d tha", e), o_arp_tx_tha, exp_sha[arp_idx]);
                if (e == 0) begin
                    // Push against a full queue in the pop cycle must be accepted.
                    arp_request(exp_sha[2], exp_spa[2], LIP, 1'b0);
                    check("rr push while full with pop", o_drop_cnt, 1);
                    finish_arp(9, exp_sha[0], exp_spa[0], "rr arp0");
                end else begin
                    if (e == 4) begin
                        i_ip_req = 1'b0;
                    end
                    finish_arp(10, exp_sha[arp_idx], exp_spa[arp_idx],
                               $sformatf("rr arp%0d", arp_idx));
                end
                arp_idx++;
            end else if (kind == 2) begin
                repeat (4) tick();
                i_ip_done = 1'b1;
                check($sformatf("rr event%0d grant at done", e), o_ip_grant, 1);
                tick();
                i_ip_done = 1'b0;
                check($sformatf("rr event%0d grant released", e), o_ip_grant, 0);
            end
        end
        i_ip_req = 1'b0;
        wait_event(60, kind, dt);
        check("rr settles idle", kind, 0);
        check("rr busy end", o_busy, 0);

        // Timeout: no arp_tx_done; pulse 4096 cycles after ARP_WAIT entry (S+1).
        arp_request(48'h0E0000000001, 32'hC0A80120, LIP, 1'b0);
        tick();
        check("to start", o_arp_tx_start, 1);
        arp_request(48'h0E0000000002, 32'hC0A80121, LIP, 1'b0);
        repeat (4095) tick();
        check("to not yet", o_tx_timeout, 0);
        tick();
        check("to pulse", o_tx_timeout, 1);
        wait_event(40, kind, dt);
        check("to next kind", kind, 1);
        check("to next delay", dt, 25);
        check("to next tha", o_arp_tx_tha, 48'h0E0000000002);
        check("to pulse single", o_tx_timeout, 0);
        finish_arp(10, 48'h0E0000000002, 32'hC0A80121, "to next");
        wait_event(60, kind, dt);
        check("to job not retried", kind, 0);
        check("to busy end", o_busy, 0);

        // Reset in ARP_WAIT with one job queued discards everything.
        arp_request(48'h0F0000000001, 32'hC0A80130, LIP, 1'b0);
        tick();
        check("rst start", o_arp_tx_start, 1);
        arp_request(48'h0F0000000002, 32'hC0A80131, LIP, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst grant", o_ip_grant, 0);
        check("rst start cleared", o_arp_tx_start, 0);
        check("rst tha", o_arp_tx_tha, 0);
        check("rst tpa", o_arp_tx_tpa, 0);
        check("rst timeout", o_tx_timeout, 0);
        check("rst drop", o_drop_cnt, 0);
        check("rst busy", o_busy, 0);
        starts_seen = 0;
        grants_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_arp_tx_start) starts_seen++;
            if (o_ip_grant) grants_seen++;
        end
        check("rst no start after release", starts_seen, 0);
        check("rst no grant after release", grants_seen, 0);
        check("rst busy after 100", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
